// File: rtl/mem_access_unit.sv
// Request sequencer in front of the data memory: single reads/writes and read bursts,
// fixed-latency sampling of mem_rdata, one response beat per word with backpressure.
module mem_access_unit #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int LEN_W     = 3,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the offering side holds its payload stable until that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int              CNT_W    = LEN_W + 1;
  localparam logic [3:0]      LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              state, state_next;
  logic [ADDR_W:0]     addr_q;
  logic [CNT_W-1:0]    count_q;
  logic [3:0]          lat_cnt;
  logic                mem_we_q;
  logic                accept, advance, access_done;
  logic [ADDR_W:0]     beat_addr_nxt;
  logic                nxt_in_range, cur_in_range;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    advance     = 1'b0;
    access_done = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt == LAT_LAST) begin
          access_done = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          if (count_q == CNT_W'(1)) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dbg_state  = state;

  // The beat address is one bit wider than the memory so overrun past the top is
  // detected instead of wrapping back to low addresses.
  assign beat_addr_nxt = (state == IDLE) ? {1'b0, req_addr} : addr_q + (ADDR_W + 1)'(1);
  assign nxt_in_range  = (beat_addr_nxt < DEPTH_A);
  assign cur_in_range  = (addr_q < DEPTH_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      count_q    <= '0;
      lat_cnt    <= '0;
      mem_addr   <= '0;
      mem_we_q   <= 1'b0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_last  <= 1'b0;
    end else if (accept) begin
      addr_q    <= beat_addr_nxt;
      count_q   <= req_we ? CNT_W'(1) : CNT_W'(req_len) + CNT_W'(1);
      lat_cnt   <= '0;
      mem_addr  <= nxt_in_range ? beat_addr_nxt[ADDR_W-1:0] : '0;
      mem_we_q  <= req_we && nxt_in_range;
      mem_wdata <= req_wdata;
    end else if (advance) begin
      addr_q   <= beat_addr_nxt;
      count_q  <= count_q - CNT_W'(1);
      lat_cnt  <= '0;
      mem_addr <= nxt_in_range ? beat_addr_nxt[ADDR_W-1:0] : '0;
      mem_we_q <= 1'b0;
    end else if (state == ACCESS) begin
      // Write enable lives only for the first access cycle: one pulse per write.
      mem_we_q <= 1'b0;
      lat_cnt  <= lat_cnt + 4'd1;
      if (access_done) begin
        resp_rdata <= cur_in_range ? mem_rdata : '0;
        resp_err   <= !cur_in_range;
        resp_last  <= (count_q == CNT_W'(1));
      end
    end
  end

  assign mem_we = mem_we_q & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural write-first memory, expected-beat
// queue filled by the driver and drained by an independent response monitor.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, resp_last;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem [512];
  logic        init_mem;
  logic        toggle_en;
  int          total = 0;
  int          bad = 0;
  int          we_cnt = 0;
  int          n_wait;
  logic [33:0] exp_q[$];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_last(resp_last),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Memory model: write-first, so a write's read-back is the new data
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 512; k++) mem[k] <= k;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_we ? mem_wdata : mem[mem_addr];

  function automatic logic [33:0] beat(input logic [31:0] d, input logic e, input logic l);
    return {d, e, l};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic we, input logic [8:0] addr, input logic [2:0] len,
                      input logic [31:0] wd, output int waited);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 after %0d cycles want ready=1", n);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waited = n;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (toggle_en) resp_ready = ~resp_ready;
    end
  end

  // Scoreboard monitor
  initial begin
    logic [33:0] cur, hold_d;
    logic        hold_v;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (resp_valid) begin
        cur = {resp_rdata, resp_err, resp_last};
        if (hold_v) check("stall_hold", cur, hold_d);
        if (resp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h want no beat", cur);
          end else begin
            check("beat", cur, exp_q.pop_front());
          end
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_d = cur;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    init_mem   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    toggle_en  = 1'b0;
    repeat (2) @(posedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_last", resp_last, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Single read, latency check
    exp_q.push_back(beat(32'd5, 1'b0, 1'b1));
    send(1'b0, 9'd5, 3'd0, 32'd0, n_wait);
    @(negedge clk);
    check("rd_mem_addr", mem_addr, 5);
    check("rd_valid_early", resp_valid, 0);
    @(negedge clk);
    check("rd_valid_on_time", resp_valid, 1);
    @(negedge clk);
    check("rd_ready_back", req_ready, 1);
    check("rd_valid_drop", resp_valid, 0);

    // Write then read back
    we_cnt = 0;
    exp_q.push_back(beat(32'hDEADBEEF, 1'b0, 1'b1));
    send(1'b1, 9'd40, 3'd5, 32'hDEADBEEF, n_wait);
    drain("wr_drain");
    exp_q.push_back(beat(32'hDEADBEEF, 1'b0, 1'b1));
    send(1'b0, 9'd40, 3'd0, 32'd0, n_wait);
    drain("wr_rd_drain");
    check("wr_we_pulses", we_cnt, 1);

    // Burst under toggling backpressure
    toggle_en = 1'b1;
    exp_q.push_back(beat(32'd10, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd11, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd12, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd13, 1'b0, 1'b1));
    send(1'b0, 9'd10, 3'd3, 32'd0, n_wait);
    drain("burst_drain");
    toggle_en = 1'b0;
    @(posedge clk);
    #3;
    resp_ready = 1'b1;

    // Burst running off the top of memory
    we_cnt = 0;
    exp_q.push_back(beat(32'd510, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd511, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd0, 1'b1, 1'b0));
    exp_q.push_back(beat(32'd0, 1'b1, 1'b1));
    send(1'b0, 9'd510, 3'd3, 32'd0, n_wait);
    drain("oor_drain");
    check("oor_no_we", we_cnt, 0);

    // Reset during beat 2 of a long burst
    exp_q.push_back(beat(32'd100, 1'b0, 1'b0));
    send(1'b0, 9'd100, 3'd7, 32'd0, n_wait);
    repeat (3) @(negedge clk);
    check("mid_state_access", dbg_state, 1);
    check("mid_beat1_seen", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_req_ready", req_ready, 1);
    rst = 1'b0;
    exp_q.push_back(beat(32'd3, 1'b0, 1'b1));
    send(1'b0, 9'd3, 3'd0, 32'd0, n_wait);
    drain("post_rst_drain");

    // Request held while busy
    exp_q.push_back(beat(32'd20, 1'b0, 1'b0));
    exp_q.push_back(beat(32'd21, 1'b0, 1'b1));
    send(1'b0, 9'd20, 3'd1, 32'd0, n_wait);
    exp_q.push_back(beat(32'd300, 1'b0, 1'b1));
    send(1'b0, 9'd300, 3'd0, 32'd0, n_wait);
    check("held_req_wait", n_wait, 4);
    drain("held_drain");
    repeat (5) @(negedge clk);
    check("no_extra_state", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bus-side sequencer placed directly upstream of the data memory (32-bit words, 512 entries). It accepts single-word read/write and multi-beat read-burst requests from the core over a valid/ready handshake, and drives the memory's address, write-enable and write-data pins. It waits a fixed memory latency, samples read data and returns one response beat per word over a valid/ready stream with backpressure. Out-of-range beats are checked and flagged; they never reach memory.

## Interface
- DATA_W, 32, data word width
- MEM_DEPTH, 512, number of memory words
- ADDR_W, $clog2(MEM_DEPTH), memory address width
- LEN_W, 3, burst length field width; max burst 2**LEN_W beats
- MEM_LAT, 1, cycles from mem_addr valid to mem_rdata sample point; legal range 1–15
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  beats minus one (reads only; ignored for writes)
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response beat available
- resp_ready  in  1  consumer accepts beat
- resp_rdata  out  DATA_W  beat data
- resp_err  out  1  beat address was out of range
- resp_last  out  1  final beat of request
- mem_addr  out  ADDR_W  to memory address bus
- mem_we  out  1  to memory write enable
- mem_wdata  out  DATA_W  to memory write data bus
- mem_rdata  in  DATA_W  from memory read data bus

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready: latch we, addr, wdata. Latch beat count = req_len+1 for reads and 1 for writes. Go to ACCESS.
- ACCESS: drive mem_addr = beat address[ADDR_W-1:0] and mem_wdata = latched wdata. Hold for MEM_LAT cycles, counted by the latency counter. On the last ACCESS cycle edge, capture resp_rdata = mem_rdata, then go to RESP.
- mem_we=1 only during the first ACCESS cycle of a write whose address is in range. A write therefore produces exactly one mem_we pulse.
- Beat address counter is ADDR_W+1 bits. A beat is in range iff its address < MEM_DEPTH.
- Out-of-range beat: mem_we=0, mem_addr=0. ACCESS timing is unchanged. Captured resp_rdata=0, resp_err=1.
- There is no wrap-around. A burst crossing MEM_DEPTH-1 returns err beats for the remainder and still emits all beats.
- RESP: resp_valid=1. resp_last=1 on the final beat. Data, err and last stay stable until resp_ready.
  - On resp_valid&&resp_ready with beats remaining: increment the address, decrement the count, return to ACCESS.
  - On the final beat: return to IDLE.
- A write response carries the memory read-back value, with err as above.
- Only one request is outstanding. req_ready=0 in ACCESS and RESP; req_valid is ignored there.
- rst (any state, including mid-burst): abort and go to IDLE. No further beats are issued. Memory contents are not restored.
- While rst is high, mem_we is forced 0.

## Timing
- Values after the first clk edge with rst high: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_last=0, mem_addr=0, mem_we=0, mem_wdata=0; state IDLE.
- A request accepted at edge N makes mem_addr valid from cycle N+1.
- resp_valid first asserts in cycle N+1+MEM_LAT.
- Each further burst beat arrives MEM_LAT+1 cycles after the previous handshake.
- req_ready returns to 1 in the cycle after the final response handshake.
- mem_we, mem_addr and mem_wdata are registered outputs; no combinational path from req_* to mem_*.

## Test plan
- Reset: memory preloaded with mem[k]=k. Read addr 5, len 0, MEM_LAT=1, resp_ready=1 → resp_valid in cycle 2 after acceptance, rdata=5, err=0, last=1; req_ready back to 1 next cycle.
- Write addr 40 data 0xDEADBEEF, then read addr 40 → exactly one mem_we pulse; read beat rdata=0xDEADBEEF.
- Read burst addr 10, len 3, resp_ready toggling 1/0 each cycle → four beats rdata 10, 11, 12, 13; last only on the 13 beat; data held stable while stalled.
- Read burst addr 510, len 3 → beats 510, 511, then two beats with rdata=0 and err=1; last on the 4th beat; mem_addr never exceeds 511.
- Reset asserted during beat 2 of a len-7 burst → next cycle resp_valid=0, mem_we=0, req_ready=1; a new read of addr 3 returns 3.
- req_valid held high during a busy burst with a different addr → not accepted until IDLE; then served once.
